coproc_arbiter: RTL and testbench

Shares the single matrix coprocessor (5×5 matrices, 8-bit operands, 9-bit results, 3-bit opcode) between N_REQ independent requesters, e.g. the HPS link manager and an on-chip test/DMA source. The block performs round-robin arbitration, latches the winner's operands, and sequences the coprocessor through reset-release / run / done. It returns the result to the owner with a valid/ack handshake and guards each job with a timeout. It sits between the requester-side managers and the coprocessor instance.

---
 rtl/coproc_pkg.sv | 25 ++
 rtl/coproc_arbiter_if.sv | 32 +++
 rtl/rr_arbiter.sv | 35 +++
 rtl/coproc_arbiter.sv | 169 ++++++++++++++++
 tb/tb_coproc_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/coproc_pkg.sv
// Shared constants and types for the matrix-coprocessor arbiter.
// Holds operand/result geometry, opcode width, the sequencer state encoding
// and a small round-robin pointer helper.
package coproc_pkg;

  localparam int unsigned ELEM_W    = 8;
  localparam int unsigned RES_W     = 9;
  localparam int unsigned N_ELEM    = 25;
  localparam int unsigned OP_W      = 3;
  localparam int unsigned MAT_W     = ELEM_W * N_ELEM;  // 200
  localparam int unsigned RES_MAT_W = RES_W * N_ELEM;   // 225

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StLoad    = 2'd1,
    StRun     = 2'd2,
    StDeliver = 2'd3
  } state_e;

  // Index following idx in a ring of n requesters.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/coproc_arbiter_if.sv
// Requester-side bundle of the coprocessor arbiter.
//   req/op_in/mat1_in/mat2_in : per-requester job request and operands (slice i = requester i)
//   res_ack                   : per-requester result acknowledge
//   gnt/res_valid/err         : per-requester grant, result valid and timeout flag
//   result                    : shared result bus, meaningful where res_valid is set
// slave is the arbiter side, master is the requester side.
interface coproc_arbiter_if #(
  parameter int unsigned N_REQ = 2
) ();
  import coproc_pkg::*;

  logic [N_REQ-1:0]       req;
  logic [OP_W*N_REQ-1:0]  op_in;
  logic [MAT_W*N_REQ-1:0] mat1_in;
  logic [MAT_W*N_REQ-1:0] mat2_in;
  logic [N_REQ-1:0]       res_ack;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       res_valid;
  logic [RES_MAT_W-1:0]   result;
  logic [N_REQ-1:0]       err;

  modport slave (
    input  req, op_in, mat1_in, mat2_in, res_ack,
    output gnt, res_valid, result, err
  );

  modport master (
    output req, op_in, mat1_in, mat2_in, res_ack,
    input  gnt, res_valid, result, err
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first requesting index at or after
// rr_ptr_i, wrapping around.
//   req_i    : request vector
//   rr_ptr_i : highest-priority index this round
//   grant_o  : one-hot winner (0 when no request)
//   idx_o    : binary winner index (0 when no request)
module rr_arbiter #(
  parameter  int unsigned N_REQ = 2,
  localparam int unsigned IdxW  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IdxW-1:0]  rr_ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IdxW-1:0]  idx_o
);

  logic            found;
  logic [IdxW-1:0] cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      cand = IdxW'((32'(rr_ptr_i) + off) % N_REQ);
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/coproc_arbiter.sv
// Shares one matrix coprocessor between N_REQ requesters.
// Round-robin picks an owner, latches its job, releases the coprocessor from
// reset, waits for done or timeout, then hands the result back with a
// valid/ack handshake.
//   clk, reset        : clock, asynchronous active-high reset
//   rq                : requester-side bundle (slave modport)
//   busy              : sequencer not idle
//   cop_rst           : coprocessor reset, high holds it idle
//   cop_op/m1/m2      : latched job presented to the coprocessor
//   cop_result/done   : coprocessor outputs
// Every output comes straight from a flop.
module coproc_arbiter
  import coproc_pkg::*;
#(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  coproc_arbiter_if.slave      rq,
  output logic                 busy,
  output logic                 cop_rst,
  output logic [OP_W-1:0]      cop_op,
  output logic [MAT_W-1:0]     cop_m1,
  output logic [MAT_W-1:0]     cop_m2,
  input  logic [RES_MAT_W-1:0] cop_result,
  input  logic                 cop_done
);

  localparam int unsigned IdxW = $clog2(N_REQ);
  localparam int unsigned CntW = $clog2(TIMEOUT);

  state_e               state_q, state_d;
  logic [IdxW-1:0]      owner_q, owner_d;
  logic [IdxW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0]     gnt_q, gnt_d;
  logic [N_REQ-1:0]     res_valid_q, res_valid_d;
  logic [N_REQ-1:0]     err_q, err_d;
  logic [RES_MAT_W-1:0] result_q, result_d;
  logic                 busy_q, busy_d;
  logic                 cop_rst_q, cop_rst_d;
  logic [OP_W-1:0]      cop_op_q, cop_op_d;
  logic [MAT_W-1:0]     cop_m1_q, cop_m1_d;
  logic [MAT_W-1:0]     cop_m2_q, cop_m2_d;
  logic [CntW-1:0]      cnt_q, cnt_d;

  logic [N_REQ-1:0]     arb_gnt;
  logic [IdxW-1:0]      arb_idx;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr_arbiter (
    .req_i    (rq.req),
    .rr_ptr_i (rr_ptr_q),
    .grant_o  (arb_gnt),
    .idx_o    (arb_idx)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    res_valid_d = res_valid_q;
    err_d       = err_q;
    result_d    = result_q;
    cop_rst_d   = cop_rst_q;
    cop_op_d    = cop_op_q;
    cop_m1_d    = cop_m1_q;
    cop_m2_d    = cop_m2_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      StIdle: begin
        cop_rst_d = 1'b1;
        if (|rq.req) begin
          state_d = StLoad;
          owner_d = arb_idx;
          gnt_d   = arb_gnt;
        end
      end

      StLoad: begin
        cop_op_d  = rq.op_in[32'(owner_q) * OP_W +: OP_W];
        cop_m1_d  = rq.mat1_in[32'(owner_q) * MAT_W +: MAT_W];
        cop_m2_d  = rq.mat2_in[32'(owner_q) * MAT_W +: MAT_W];
        cnt_d     = '0;
        cop_rst_d = 1'b0;  // registered, so the coprocessor leaves reset as RUN begins
        state_d   = StRun;
      end

      StRun: begin
        cnt_d = cnt_q + CntW'(1);
        // A requester that already dropped req never sees res_valid; the
        // job still finishes and DELIVER just retires it.
        if (cop_done) begin
          result_d    = cop_result;
          err_d       = '0;
          res_valid_d = gnt_q & rq.req;
          cop_rst_d   = 1'b1;
          state_d     = StDeliver;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          result_d    = '0;
          err_d       = gnt_q & rq.req;
          res_valid_d = gnt_q & rq.req;
          cop_rst_d   = 1'b1;
          state_d     = StDeliver;
        end
      end

      StDeliver: begin
        if (rq.res_ack[owner_q] || !rq.req[owner_q]) begin
          rr_ptr_d    = IdxW'(rr_next(32'(owner_q), N_REQ));
          gnt_d       = '0;
          res_valid_d = '0;
          err_d       = '0;
          state_d     = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      res_valid_q <= '0;
      err_q       <= '0;
      result_q    <= '0;
      busy_q      <= 1'b0;
      cop_rst_q   <= 1'b1;
      cop_op_q    <= '0;
      cop_m1_q    <= '0;
      cop_m2_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
      result_q    <= result_d;
      busy_q      <= busy_d;
      cop_rst_q   <= cop_rst_d;
      cop_op_q    <= cop_op_d;
      cop_m1_q    <= cop_m1_d;
      cop_m2_q    <= cop_m2_d;
      cnt_q       <= cnt_d;
    end
  end

  assign rq.gnt       = gnt_q;
  assign rq.res_valid = res_valid_q;
  assign rq.err       = err_q;
  assign rq.result    = result_q;
  assign busy         = busy_q;
  assign cop_rst      = cop_rst_q;
  assign cop_op       = cop_op_q;
  assign cop_m1       = cop_m1_q;
  assign cop_m2       = cop_m2_q;

endmodule

// File: tb/tb_coproc_arbiter.sv
// Scoreboard bench for coproc_arbiter: the driver predicts the service order
// with a round-robin model and queues expected responses; the monitor pops
// and compares whenever res_valid appears, then acknowledges.
module tb_coproc_arbiter;
  import coproc_pkg::*;

  localparam int unsigned N_REQ   = 2;
  localparam int unsigned TIMEOUT = 16;

  typedef struct {
    int                   idx;
    logic                 err;
    logic [RES_MAT_W-1:0] res;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 busy;
  logic                 cop_rst;
  logic                 cop_done = 1'b0;
  logic [OP_W-1:0]      cop_op;
  logic [MAT_W-1:0]     cop_m1;
  logic [MAT_W-1:0]     cop_m2;
  logic [RES_MAT_W-1:0] cop_result;

  coproc_arbiter_if #(.N_REQ(N_REQ)) bus ();

  coproc_arbiter #(
    .N_REQ   (N_REQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rq         (bus),
    .busy       (busy),
    .cop_rst    (cop_rst),
    .cop_op     (cop_op),
    .cop_m1     (cop_m1),
    .cop_m2     (cop_m2),
    .cop_result (cop_result),
    .cop_done   (cop_done)
  );

  always #5 clk = ~clk;

  // Stimulus and model state
  logic [N_REQ-1:0]  req_drv = '0;
  int                round_id = 0;
  int                drop_round [N_REQ];
  logic [OP_W-1:0]   op_a [N_REQ];
  logic [ELEM_W-1:0] m1_a [N_REQ][N_ELEM];
  logic [ELEM_W-1:0] m2_a [N_REQ][N_ELEM];
  int                lat [N_REQ];
  int                model_ptr = 0;
  exp_t              exp_q [$];
  int                n_checks = 0;
  int                n_fail = 0;
  int                run_k = 0;

  // A requester holds req until the monitor acknowledges its result this round.
  always_comb begin
    bus.req = '0;
    for (int i = 0; i < N_REQ; i++) bus.req[i] = req_drv[i] && (drop_round[i] != round_id);
  end

  // Coprocessor stand-in: element-wise m1 + m2 + op, done after lat[owner] RUN cycles.
  always_comb begin
    cop_result = '0;
    for (int e = 0; e < N_ELEM; e++)
      cop_result[e*RES_W +: RES_W] = {1'b0, cop_m1[e*ELEM_W +: ELEM_W]}
                                   + {1'b0, cop_m2[e*ELEM_W +: ELEM_W]} + RES_W'(cop_op);
  end

  function automatic int onehot_idx(input logic [N_REQ-1:0] g);
    for (int i = 0; i < N_REQ; i++) if (g[i]) return i;
    return 0;
  endfunction

  always @(negedge clk) begin
    if (cop_rst) begin
      run_k    <= 0;
      cop_done <= 1'b0;
    end else begin
      cop_done <= (run_k == lat[onehot_idx(bus.gnt)]);
      run_k    <= run_k + 1;
    end
  end

  function automatic void check(input string name, input logic [RES_MAT_W-1:0] act_v,
                                input logic [RES_MAT_W-1:0] exp_v);
    n_checks++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act_v, exp_v);
    end
  endfunction

  function automatic logic [RES_MAT_W-1:0] model_result(input int i);
    logic [RES_MAT_W-1:0] r;
    r = '0;
    for (int e = 0; e < N_ELEM; e++)
      r[e*RES_W +: RES_W] = RES_W'((32'(m1_a[i][e]) + 32'(m2_a[i][e]) + 32'(op_a[i]))
                                   % (1 << RES_W));
    return r;
  endfunction

  task automatic gen_job(input int i);
    op_a[i] = OP_W'($urandom_range(0, 7));
    for (int e = 0; e < N_ELEM; e++) begin
      m1_a[i][e] = ELEM_W'($urandom_range(0, 255));
      m2_a[i][e] = ELEM_W'($urandom_range(0, 255));
    end
    lat[i] = $urandom_range(0, TIMEOUT + 3);
  endtask

  task automatic pack_all();
    for (int i = 0; i < N_REQ; i++) begin
      bus.op_in[i*OP_W +: OP_W] = op_a[i];
      for (int e = 0; e < N_ELEM; e++) begin
        bus.mat1_in[(i*N_ELEM + e)*ELEM_W +: ELEM_W] = m1_a[i][e];
        bus.mat2_in[(i*N_ELEM + e)*ELEM_W +: ELEM_W] = m2_a[i][e];
      end
    end
  endtask

  // Service order when mask is raised at once: repeatedly take the first
  // pending requester at or after the pointer, then move the pointer past it.
  task automatic push_expected(input logic [N_REQ-1:0] mask);
    logic [N_REQ-1:0] pend;
    exp_t             e;
    int               w;
    int               c;
    pend = mask;
    while (pend != '0) begin
      w = -1;
      for (int k = 0; k < N_REQ; k++) begin
        c = (model_ptr + k) % N_REQ;
        if (w < 0 && pend[c]) w = c;
      end
      pend[w]   = 1'b0;
      model_ptr = (w + 1) % N_REQ;
      e.idx     = w;
      e.err     = (lat[w] >= int'(TIMEOUT));
      e.res     = e.err ? '0 : model_result(w);
      exp_q.push_back(e);
    end
  endtask

  task automatic issue(input logic [N_REQ-1:0] mask);
    round_id++;
    req_drv = mask;
  endtask

  task automatic wait_idle(input int bound);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && bus.req == '0) ok = 1'b1;
    end
    check("drain", 225'(ok), 225'(1));
    req_drv = '0;
  endtask

  task automatic wait_run(input int bound);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      if (cop_rst == 1'b0) ok = 1'b1;
    end
    check("run_start", 225'(ok), 225'(1));
  endtask

  // Monitor: compare each delivered result against the scoreboard, then ack.
  initial begin
    exp_t             e;
    int               d;
    logic [N_REQ-1:0] own;
    bus.res_ack = '0;
    for (int i = 0; i < N_REQ; i++) drop_round[i] = -1;
    forever begin
      @(negedge clk);
      if (!reset && bus.res_valid != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 225'(bus.res_valid), 225'(0));
          own = bus.res_valid;
          e.idx = onehot_idx(own);
        end else begin
          e   = exp_q.pop_front();
          own = N_REQ'(1) << e.idx;
          check("res_valid", 225'(bus.res_valid), 225'(own));
          check("gnt_deliver", 225'(bus.gnt), 225'(own));
          check("err", 225'(bus.err), 225'(e.err ? own : '0));
          check("result", bus.result, e.res);
          check("cop_rst_deliver", 225'(cop_rst), 225'(1));
          d = $urandom_range(0, 2);
          repeat (d) begin
            bus.res_ack = ~own;  // non-owner acks must be ignored
            @(negedge clk);
            check("valid_hold", 225'(bus.res_valid), 225'(own));
          end
        end
        bus.res_ack = own;
        drop_round[e.idx] = round_id;
        @(negedge clk);
        bus.res_ack = '0;
      end
    end
  end

  // Driver
  initial begin
    bit seen;
    for (int i = 0; i < N_REQ; i++) begin
      op_a[i] = '0;
      lat[i]  = 0;
      for (int e = 0; e < N_ELEM; e++) begin
        m1_a[i][e] = '0;
        m2_a[i][e] = '0;
      end
    end
    pack_all();
    repeat (2) @(negedge clk);
    check("rst_gnt", 225'(bus.gnt), 225'(0));
    check("rst_res_valid", 225'(bus.res_valid), 225'(0));
    check("rst_err", 225'(bus.err), 225'(0));
    check("rst_result", bus.result, 225'(0));
    check("rst_busy", 225'(busy), 225'(0));
    check("rst_cop_rst", 225'(cop_rst), 225'(1));
    check("rst_cop_op", 225'(cop_op), 225'(0));
    check("rst_cop_m1", 225'(cop_m1), 225'(0));
    check("rst_cop_m2", 225'(cop_m2), 225'(0));
    reset = 1'b0;
    @(negedge clk);

    // Single job: m1 all 1, m2 all 2, op 0, done 5 cycles into RUN
    op_a[0] = '0;
    for (int e = 0; e < N_ELEM; e++) begin
      m1_a[0][e] = 8'd1;
      m2_a[0][e] = 8'd2;
    end
    lat[0] = 5;
    pack_all();
    push_expected(2'b01);
    issue(2'b01);
    @(negedge clk);
    check("load_gnt", 225'(bus.gnt), 225'(2'b01));
    check("load_cop_rst", 225'(cop_rst), 225'(1));
    check("load_busy", 225'(busy), 225'(1));
    @(negedge clk);
    check("run_cop_rst", 225'(cop_rst), 225'(0));
    check("run_cop_m1", 225'(cop_m1), 225'(bus.mat1_in[MAT_W-1:0]));
    check("run_cop_m2", 225'(cop_m2), 225'(bus.mat2_in[MAT_W-1:0]));
    check("run_cop_op", 225'(cop_op), 225'(0));
    wait_idle(100);
    check("single_idle", 225'(busy), 225'(0));

    // Fairness: both request together, short jobs
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N_REQ; i++) begin
        gen_job(i);
        lat[i] = $urandom_range(0, 4);
      end
      pack_all();
      push_expected(2'b11);
      issue(2'b11);
      wait_idle(200);
    end

    // Abandon: requester 1 drops req during RUN
    gen_job(1);
    lat[1] = 6;
    pack_all();
    issue(2'b10);
    wait_run(20);
    repeat (2) @(negedge clk);
    req_drv[1] = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (bus.res_valid != '0) seen = 1'b1;
    end
    check("abandon_no_valid", 225'(seen), 225'(0));
    check("abandon_idle", 225'(busy), 225'(0));
    model_ptr = 0;
    for (int i = 0; i < N_REQ; i++) gen_job(i);
    pack_all();
    push_expected(2'b11);
    issue(2'b11);
    wait_idle(200);

    // Reset three cycles into RUN
    gen_job(0);
    lat[0] = TIMEOUT + 5;
    pack_all();
    issue(2'b01);
    wait_run(20);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_cop_rst", 225'(cop_rst), 225'(1));
    check("midrst_gnt", 225'(bus.gnt), 225'(0));
    check("midrst_busy", 225'(busy), 225'(0));
    check("midrst_valid", 225'(bus.res_valid), 225'(0));
    model_ptr = 0;
    lat[0] = 4;
    @(negedge clk);
    reset = 1'b0;
    push_expected(2'b01);
    @(negedge clk);
    check("postrst_gnt", 225'(bus.gnt), 225'(2'b01));
    wait_idle(100);

    // Done in the final RUN cycle beats the timeout; one cycle later it does not
    gen_job(0);
    lat[0] = TIMEOUT - 1;
    pack_all();
    push_expected(2'b01);
    issue(2'b01);
    wait_idle(100);
    gen_job(1);
    lat[1] = TIMEOUT;
    pack_all();
    push_expected(2'b10);
    issue(2'b10);
    wait_idle(100);

    // Random rounds
    for (int r = 0; r < 25; r++) begin
      logic [N_REQ-1:0] mask;
      mask = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
      for (int i = 0; i < N_REQ; i++) if (mask[i]) gen_job(i);
      pack_all();
      push_expected(mask);
      issue(mask);
      wait_idle(400);
    end

    check("queue_empty", 225'(exp_q.size()), 225'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
